// File: rtl/pipeline_ctrl_pkg.sv
// Shared FSM state encoding and hazard-source priority ordering for the
// pipeline stall controller.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      StRun      = 2'd0,
      StDmemWait = 2'd1,
      StImemWait = 2'd2,
      StFlushed  = 2'd3
   } ctrl_state_e;

   // Numeric order is the arbitration order: the larger value wins.
   typedef enum logic [2:0] {
      CauseNone    = 3'd0,
      CauseImem    = 3'd1,
      CauseLoadUse = 3'd2,
      CauseBranch  = 3'd3,
      CauseDmem    = 3'd4
   } cause_e;

   function automatic cause_e pick_cause(input logic dmem_busy, input logic branch,
                                         input logic load_use, input logic imem_busy);
      if (dmem_busy) return CauseDmem;
      if (branch)    return CauseBranch;
      if (load_use)  return CauseLoadUse;
      if (imem_busy) return CauseImem;
      return CauseNone;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous reset.
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             INC,
   output logic [WIDTH-1:0] COUNT
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (INC && (count_q != '1)) count_d = count_q + WIDTH'(1);
   end

   always_ff @(posedge CLK) begin
      if (RESET) count_q <= '0;
      else       count_q <= count_d;
   end

   assign COUNT = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Arbitrates pipeline hazards into stall/flush/bubble controls and keeps
// saturating stall and bubble performance counters.
module pipeline_stall_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 LU_HAZ_SIG,
   input  logic                 BRANCH_TAKEN,
   input  logic                 DATA_MEM_BUSY,
   input  logic                 INST_MEM_BUSY,
   output logic                 PC_STALL,
   output logic                 IF_ID_STALL,
   output logic                 ID_EX_STALL,
   output logic                 EX_MEM_STALL,
   output logic                 IF_ID_FLUSH,
   output logic                 ID_EX_BUBBLE,
   output logic                 MEM_WB_BUBBLE,
   output logic [CNT_WIDTH-1:0] STALL_CYCLES,
   output logic [CNT_WIDTH-1:0] BUBBLE_COUNT,
   output logic                 HAZ_ERROR
);

   ctrl_state_e state_q, state_d;
   cause_e      cause;
   logic        lu_live;
   logic        lu_bubble;
   logic        lu_prev_q;
   logic        haz_error_q, haz_error_d;

   // ID holds a flushed NOP right after a redirect, so its load-use signal is stale.
   assign lu_live = LU_HAZ_SIG && (state_q != StFlushed);
   assign cause   = pick_cause(DATA_MEM_BUSY, BRANCH_TAKEN, lu_live, INST_MEM_BUSY);

   always_comb begin
      PC_STALL      = 1'b0;
      IF_ID_STALL   = 1'b0;
      ID_EX_STALL   = 1'b0;
      EX_MEM_STALL  = 1'b0;
      IF_ID_FLUSH   = 1'b0;
      ID_EX_BUBBLE  = 1'b0;
      MEM_WB_BUBBLE = 1'b0;
      lu_bubble     = 1'b0;
      state_d       = StRun;
      if (!RESET) begin
         unique case (cause)
            CauseDmem: begin
               PC_STALL      = 1'b1;
               IF_ID_STALL   = 1'b1;
               ID_EX_STALL   = 1'b1;
               EX_MEM_STALL  = 1'b1;
               MEM_WB_BUBBLE = 1'b1;
               state_d       = StDmemWait;
            end
            CauseBranch: begin
               IF_ID_FLUSH  = 1'b1;
               ID_EX_BUBBLE = 1'b1;
               state_d      = StFlushed;
            end
            CauseLoadUse: begin
               PC_STALL     = 1'b1;
               IF_ID_STALL  = 1'b1;
               ID_EX_BUBBLE = 1'b1;
               lu_bubble    = 1'b1;
            end
            CauseImem: begin
               PC_STALL    = 1'b1;
               IF_ID_FLUSH = 1'b1;
               state_d     = StImemWait;
            end
            CauseNone: state_d = StRun;
         endcase
      end
   end

   assign haz_error_d = haz_error_q | (lu_bubble & lu_prev_q);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= StRun;
         lu_prev_q   <= 1'b0;
         haz_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lu_prev_q   <= lu_bubble;
         haz_error_q <= haz_error_d;
      end
   end

   assign HAZ_ERROR = haz_error_q;

   sat_counter #(
      .WIDTH(CNT_WIDTH)
   ) u_stall_cnt (
      .CLK  (CLK),
      .RESET(RESET),
      .INC  (PC_STALL),
      .COUNT(STALL_CYCLES)
   );

   sat_counter #(
      .WIDTH(CNT_WIDTH)
   ) u_bubble_cnt (
      .CLK  (CLK),
      .RESET(RESET),
      .INC  (ID_EX_BUBBLE | MEM_WB_BUBBLE),
      .COUNT(BUBBLE_COUNT)
   );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed and randomized checks of pipeline_stall_controller against a
// rule-level reference model, with 4-bit counters so saturation is reachable.
module tb_pipeline_stall_controller;

   localparam int unsigned W = 4;
   // Control vector: {PC, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, IF_ID_FLUSH, ID_EX_BUBBLE, MEM_WB_BUBBLE}
   localparam logic [6:0] C_DMEM = 7'b1111001;
   localparam logic [6:0] C_BR   = 7'b0000110;
   localparam logic [6:0] C_LU   = 7'b1100010;
   localparam logic [6:0] C_IMEM = 7'b1000100;
   localparam logic [6:0] C_NONE = 7'b0000000;

   logic CLK = 1'b0;
   logic RESET, LU_HAZ_SIG, BRANCH_TAKEN, DATA_MEM_BUSY, INST_MEM_BUSY;
   logic PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL;
   logic IF_ID_FLUSH, ID_EX_BUBBLE, MEM_WB_BUBBLE, HAZ_ERROR;
   logic [W-1:0] STALL_CYCLES, BUBBLE_COUNT;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [W-1:0] m_stall = '0, m_bub = '0;
   logic m_err = 1'b0, m_prev_lu = 1'b0, m_flushed = 1'b0;
   logic [6:0] exp_ctl, obs_ctl;
   logic [W-1:0] obs_stall, obs_bub;
   logic obs_err;

   always #5 CLK = ~CLK;

   pipeline_stall_controller #(.CNT_WIDTH(W)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .LU_HAZ_SIG   (LU_HAZ_SIG),
      .BRANCH_TAKEN (BRANCH_TAKEN),
      .DATA_MEM_BUSY(DATA_MEM_BUSY),
      .INST_MEM_BUSY(INST_MEM_BUSY),
      .PC_STALL     (PC_STALL),
      .IF_ID_STALL  (IF_ID_STALL),
      .ID_EX_STALL  (ID_EX_STALL),
      .EX_MEM_STALL (EX_MEM_STALL),
      .IF_ID_FLUSH  (IF_ID_FLUSH),
      .ID_EX_BUBBLE (ID_EX_BUBBLE),
      .MEM_WB_BUBBLE(MEM_WB_BUBBLE),
      .STALL_CYCLES (STALL_CYCLES),
      .BUBBLE_COUNT (BUBBLE_COUNT),
      .HAZ_ERROR    (HAZ_ERROR)
   );

   // Drives one cycle, samples controls mid-cycle and registered state after the edge,
   // and advances the reference model.
   task automatic run_cycle(input logic r, input logic d, input logic b, input logic l,
                            input logic i);
      logic lu_b, br;
      RESET = r; DATA_MEM_BUSY = d; BRANCH_TAKEN = b; LU_HAZ_SIG = l; INST_MEM_BUSY = i;
      exp_ctl = C_NONE; lu_b = 1'b0; br = 1'b0;
      if (!r) begin
         if (d) exp_ctl = C_DMEM;
         else if (b) begin exp_ctl = C_BR; br = 1'b1; end
         else if (l && !m_flushed) begin exp_ctl = C_LU; lu_b = 1'b1; end
         else if (i) exp_ctl = C_IMEM;
      end
      @(negedge CLK);
      obs_ctl = {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL,
                 IF_ID_FLUSH, ID_EX_BUBBLE, MEM_WB_BUBBLE};
      @(posedge CLK);
      #1;
      if (r) begin
         m_stall = '0; m_bub = '0; m_err = 1'b0; m_prev_lu = 1'b0; m_flushed = 1'b0;
      end else begin
         if (exp_ctl[6] && m_stall != '1) m_stall = m_stall + 1'b1;
         if ((exp_ctl[1] || exp_ctl[0]) && m_bub != '1) m_bub = m_bub + 1'b1;
         m_err = m_err | (lu_b & m_prev_lu);
         m_prev_lu = lu_b;
         m_flushed = br;
      end
      obs_stall = STALL_CYCLES; obs_bub = BUBBLE_COUNT; obs_err = HAZ_ERROR;
   endtask

   task automatic test_reset();
      run_cycle(1, 1, 1, 1, 1);
      n_cmp++;
      if (obs_ctl !== C_NONE) begin
         n_bad++; $display("FAIL reset_ctl: got %b want %b", obs_ctl, C_NONE);
      end
      run_cycle(1, 1, 1, 1, 1);
      n_cmp++;
      if ({obs_stall, obs_bub, obs_err} !== {4'h0, 4'h0, 1'b0}) begin
         n_bad++; $display("FAIL reset_state: got %h/%h/%b want 0/0/0", obs_stall, obs_bub, obs_err);
      end
   endtask

   task automatic test_lu_single();
      run_cycle(1, 0, 0, 0, 0);
      run_cycle(0, 0, 0, 1, 0);
      n_cmp++;
      if (obs_ctl !== C_LU) begin
         n_bad++; $display("FAIL lu_ctl: got %b want %b", obs_ctl, C_LU);
      end
      n_cmp++;
      if ({obs_stall, obs_bub, obs_err} !== {4'h1, 4'h1, 1'b0}) begin
         n_bad++; $display("FAIL lu_counts: got %h/%h/%b want 1/1/0", obs_stall, obs_bub, obs_err);
      end
      run_cycle(0, 0, 0, 0, 0);
      n_cmp++;
      if (obs_ctl !== C_NONE) begin
         n_bad++; $display("FAIL lu_release: got %b want %b", obs_ctl, C_NONE);
      end
   endtask

   task automatic test_dmem_lu();
      run_cycle(1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         run_cycle(0, 1, 0, 1, 0);
         n_cmp++;
         if (obs_ctl !== C_DMEM) begin
            n_bad++; $display("FAIL dmem_ctl[%0d]: got %b want %b", k, obs_ctl, C_DMEM);
         end
      end
      n_cmp++;
      if (obs_stall !== 4'h3) begin
         n_bad++; $display("FAIL dmem_stalls: got %h want 3", obs_stall);
      end
      run_cycle(0, 0, 0, 1, 0);
      n_cmp++;
      if (obs_ctl !== C_LU || obs_err !== 1'b0) begin
         n_bad++; $display("FAIL dmem_then_lu: got %b/%b want %b/0", obs_ctl, obs_err, C_LU);
      end
   endtask

   task automatic test_branch_lu();
      run_cycle(1, 0, 0, 0, 0);
      run_cycle(0, 0, 1, 1, 0);
      n_cmp++;
      if (obs_ctl !== C_BR) begin
         n_bad++; $display("FAIL branch_ctl: got %b want %b", obs_ctl, C_BR);
      end
      run_cycle(0, 0, 0, 1, 0);
      n_cmp++;
      if (obs_ctl !== C_NONE || obs_err !== 1'b0) begin
         n_bad++; $display("FAIL flushed_mask: got %b/%b want %b/0", obs_ctl, obs_err, C_NONE);
      end
      run_cycle(0, 0, 0, 1, 0);
      n_cmp++;
      if (obs_ctl !== C_LU || obs_err !== 1'b0) begin
         n_bad++; $display("FAIL flushed_one_cycle: got %b/%b want %b/0", obs_ctl, obs_err, C_LU);
      end
   endtask

   task automatic test_haz_error();
      run_cycle(1, 0, 0, 0, 0);
      run_cycle(0, 0, 0, 1, 0);
      n_cmp++;
      if (obs_err !== 1'b0) begin
         n_bad++; $display("FAIL haz_first: got %b want 0", obs_err);
      end
      run_cycle(0, 0, 0, 1, 0);
      n_cmp++;
      if (obs_ctl !== C_LU || obs_err !== 1'b1) begin
         n_bad++; $display("FAIL haz_second: got %b/%b want %b/1", obs_ctl, obs_err, C_LU);
      end
      for (int k = 0; k < 3; k++) run_cycle(0, 0, 0, 0, 0);
      n_cmp++;
      if (obs_err !== 1'b1) begin
         n_bad++; $display("FAIL haz_sticky: got %b want 1", obs_err);
      end
      run_cycle(1, 0, 0, 0, 0);
      n_cmp++;
      if (obs_err !== 1'b0) begin
         n_bad++; $display("FAIL haz_clear: got %b want 0", obs_err);
      end
   endtask

   task automatic test_imem();
      run_cycle(1, 0, 0, 0, 0);
      run_cycle(0, 0, 0, 0, 1);
      n_cmp++;
      if (obs_ctl !== C_IMEM) begin
         n_bad++; $display("FAIL imem_ctl: got %b want %b", obs_ctl, C_IMEM);
      end
      run_cycle(0, 0, 0, 1, 1);
      n_cmp++;
      if (obs_ctl !== C_LU) begin
         n_bad++; $display("FAIL imem_lu: got %b want %b", obs_ctl, C_LU);
      end
      run_cycle(0, 0, 0, 0, 0);
      n_cmp++;
      if (obs_ctl !== C_NONE) begin
         n_bad++; $display("FAIL imem_exit: got %b want %b", obs_ctl, C_NONE);
      end
   endtask

   task automatic test_saturation();
      run_cycle(1, 0, 0, 0, 0);
      for (int k = 0; k < 14; k++) run_cycle(0, 0, 0, 0, 1);
      n_cmp++;
      if (obs_stall !== 4'hE) begin
         n_bad++; $display("FAIL sat_pre: got %h want e", obs_stall);
      end
      for (int k = 0; k < 3; k++) run_cycle(0, 1, 0, 0, 0);
      n_cmp++;
      if (obs_stall !== 4'hF || obs_bub !== 4'h3) begin
         n_bad++; $display("FAIL sat_hold: got %h/%h want f/3", obs_stall, obs_bub);
      end
   endtask

   task automatic test_reset_mid_seq();
      run_cycle(1, 0, 0, 0, 0);
      run_cycle(0, 1, 0, 0, 0);
      run_cycle(0, 1, 0, 0, 0);
      run_cycle(1, 1, 0, 0, 0);
      n_cmp++;
      if (obs_ctl !== C_NONE || {obs_stall, obs_bub, obs_err} !== 9'h0) begin
         n_bad++; $display("FAIL rst_dmem: got %b %h/%h/%b want 0 0/0/0",
                           obs_ctl, obs_stall, obs_bub, obs_err);
      end
      run_cycle(0, 0, 0, 1, 0);
      n_cmp++;
      if (obs_ctl !== C_LU) begin
         n_bad++; $display("FAIL rst_dmem_run: got %b want %b", obs_ctl, C_LU);
      end
      run_cycle(0, 0, 1, 0, 0);
      run_cycle(1, 0, 0, 0, 0);
      run_cycle(0, 0, 0, 1, 0);
      n_cmp++;
      if (obs_ctl !== C_LU) begin
         n_bad++; $display("FAIL rst_flushed_run: got %b want %b", obs_ctl, C_LU);
      end
   endtask

   task automatic test_random();
      run_cycle(1, 0, 0, 0, 0);
      for (int k = 0; k < 600; k++) begin
         run_cycle(($urandom_range(39) == 0), ($urandom_range(3) == 0), ($urandom_range(4) == 0),
                   ($urandom_range(1) == 0), ($urandom_range(2) == 0));
         n_cmp++;
         if (obs_ctl !== exp_ctl) begin
            n_bad++; $display("FAIL rand_ctl[%0d]: got %b want %b", k, obs_ctl, exp_ctl);
         end
         n_cmp++;
         if ((obs_ctl[5] && obs_ctl[2]) || (obs_ctl[4] && obs_ctl[1])) begin
            n_bad++; $display("FAIL rand_exclusive[%0d]: got %b want no stall+flush/bubble", k, obs_ctl);
         end
         n_cmp++;
         if ({obs_stall, obs_bub, obs_err} !== {m_stall, m_bub, m_err}) begin
            n_bad++; $display("FAIL rand_state[%0d]: got %h/%h/%b want %h/%h/%b",
                              k, obs_stall, obs_bub, obs_err, m_stall, m_bub, m_err);
         end
      end
   endtask

   initial begin
      RESET = 1'b1; LU_HAZ_SIG = 1'b0; BRANCH_TAKEN = 1'b0;
      DATA_MEM_BUSY = 1'b0; INST_MEM_BUSY = 1'b0;
      @(posedge CLK);
      #1;
      test_reset();
      test_lu_single();
      test_dmem_lu();
      test_branch_lu();
      test_haz_error();
      test_imem();
      test_saturation();
      test_reset_mid_seq();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, meaning width of both performance counters.
REQ-002 SHALL have port CLK  input  1  pipeline clock, all state on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port LU_HAZ_SIG  input  1  load-use hazard from hazard_detection_unit, ID vs EX.
REQ-005 SHALL have port BRANCH_TAKEN  input  1  EX-stage resolved redirect (branch/jump mispredict).
REQ-006 SHALL have port DATA_MEM_BUSY  input  1  data memory not ready; MEM stage must hold.
REQ-007 SHALL have port INST_MEM_BUSY  input  1  instruction memory not ready; fetch must hold.
REQ-008 SHALL have port PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL  output  1 each  hold the PC or named pipeline register.
REQ-009 SHALL have port IF_ID_FLUSH, ID_EX_BUBBLE, MEM_WB_BUBBLE  output  1 each  load NOP into the named register.
REQ-010 SHALL have port STALL_CYCLES, BUBBLE_COUNT  output  CNT_WIDTH each  saturating performance counters.
REQ-011 SHALL have port HAZ_ERROR  output  1  sticky; LU_HAZ_SIG held more than one consecutive RUN cycle.

Function
REQ-012 SHALL implement FSM states RUN, DMEM_WAIT, IMEM_WAIT, FLUSHED.
REQ-013 SHALL derive control outputs combinationally from state and inputs; priority: DATA_MEM_BUSY > BRANCH_TAKEN > LU_HAZ_SIG > INST_MEM_BUSY.
REQ-014 DATA_MEM_BUSY=1 SHALL assert PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_BUBBLE; no other outputs; next state DMEM_WAIT.
REQ-015 DMEM_WAIT SHALL persist while DATA_MEM_BUSY=1; on deassertion behave as RUN in that same cycle.
REQ-016 BRANCH_TAKEN=1 (no DATA_MEM_BUSY) SHALL assert IF_ID_FLUSH and ID_EX_BUBBLE, deassert PC_STALL, ignore LU_HAZ_SIG; next state FLUSHED.
REQ-017 FLUSHED SHALL last exactly one cycle, masking LU_HAZ_SIG (ID holds a flushed NOP); next state RUN unless a higher-priority input applies.
REQ-018 LU_HAZ_SIG=1 in RUN SHALL assert PC_STALL, IF_ID_STALL, ID_EX_BUBBLE for exactly one cycle (one bubble per load).
REQ-019 LU_HAZ_SIG=1 in two consecutive RUN cycles SHALL set HAZ_ERROR on the next edge; bubble is still inserted.
REQ-020 INST_MEM_BUSY=1 (no higher-priority input) SHALL assert PC_STALL and IF_ID_FLUSH; next state IMEM_WAIT; exit the cycle INST_MEM_BUSY=0.
REQ-021 Simultaneous LU_HAZ_SIG and INST_MEM_BUSY SHALL assert PC_STALL, IF_ID_STALL, ID_EX_BUBBLE (stall dominates flush for IF/ID).
REQ-022 STALL_CYCLES SHALL increment each cycle PC_STALL=1; BUBBLE_COUNT each cycle ID_EX_BUBBLE=1 or MEM_WB_BUBBLE=1 (by 1 only); both saturate at all-ones.
REQ-023 IF_ID_STALL and IF_ID_FLUSH SHALL never both be 1; ID_EX_STALL and ID_EX_BUBBLE SHALL never both be 1.

Reset
REQ-024 RESET=1 at a rising edge SHALL set state RUN, counters 0, HAZ_ERROR 0, regardless of current state.
REQ-025 While RESET=1, all stall/flush/bubble outputs SHALL be 0.
REQ-026 Reset during DMEM_WAIT or FLUSHED SHALL abandon the sequence; first post-reset cycle evaluates inputs as RUN.

Structure
REQ-027 SHALL place FSM state encoding (2-bit) and priority constants in shared package pipeline_ctrl_pkg.
REQ-028 SHALL instantiate sub-module sat_counter (parameter WIDTH; inputs CLK, RESET, INC) twice for the counters.
REQ-029 SHALL contain no combinational path from counters or HAZ_ERROR to control outputs.

Verification
REQ-030 LU_HAZ_SIG=1 one cycle in RUN -> PC_STALL=IF_ID_STALL=ID_EX_BUBBLE=1 that cycle, STALL_CYCLES=1, BUBBLE_COUNT=1, HAZ_ERROR=0.
REQ-031 DATA_MEM_BUSY=1 for 3 cycles with LU_HAZ_SIG=1 -> 3 cycles full stall plus MEM_WB_BUBBLE, no ID_EX_BUBBLE; STALL_CYCLES=3; LU bubble on 4th cycle.
REQ-032 BRANCH_TAKEN=1 and LU_HAZ_SIG=1 together, LU_HAZ_SIG held next cycle -> IF_ID_FLUSH=ID_EX_BUBBLE=1, PC_STALL=0; next cycle all outputs 0, HAZ_ERROR=0.
REQ-033 LU_HAZ_SIG=1 two consecutive RUN cycles -> HAZ_ERROR=1 from third edge, stays 1 until RESET.
REQ-034 Force counters to all-ones minus 1 (CNT_WIDTH=4), stall 3 cycles -> STALL_CYCLES=4'hF, no wrap.
REQ-035 RESET=1 mid DMEM_WAIT -> next cycle outputs 0, state RUN, counters 0.
